// File: rtl/axi_wr_burst_gen_pkg.sv
// axi_wr_burst_gen_pkg: burst/response codes, write descriptor, FSM states and legality check
// No ports; imported by the burst engine, its beat-address helper and the stimulus side.
package axi_wr_burst_gen_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int CMD_ID_W   = 4;
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;
  typedef struct packed {
    logic [CMD_ID_W-1:0]   id;
    logic [CMD_ADDR_W-1:0] addr;
    logic [3:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [CMD_DATA_W-1:0] data;
  } wr_cmd_t;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP, ST_DONE} state_t;
  // WRAP bursts must cover a power-of-two number of beats
  function automatic logic cmd_illegal(input logic [2:0] size, input logic [1:0] burst, input logic [3:0] len);
    return size > 3'd2 || burst == 2'b11 || (burst == BURST_WRAP && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction
endpackage

// File: rtl/axi_beat_addr.sv
// axi_beat_addr: combinational next-beat address and byte strobes for AXI bursts
// in: addr, size, burst, len; out: next_addr, strb (lanes of addr), next_strb (lanes of next_addr).
module axi_beat_addr
  import axi_wr_burst_gen_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int STRB_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  input  logic [3:0]        len,
  output logic [ADDR_W-1:0] next_addr,
  output logic [STRB_W-1:0] strb,
  output logic [STRB_W-1:0] next_strb
);
  logic [ADDR_W-1:0] inc, mask;
  // 1<<size ones, shifted to the size-aligned lane offset within the bus word
  function automatic logic [STRB_W-1:0] strb_of(input logic [ADDR_W-1:0] a, input logic [2:0] s);
    logic [STRB_W-1:0] ones;
    logic [31:0] off;
    ones = STRB_W'((32'd1 << (32'd1 << s)) - 32'd1);
    off = 32'(a & ADDR_W'(STRB_W - 1)) & ~((32'd1 << s) - 32'd1);
    return ones << off;
  endfunction
  always_comb begin
    inc = addr + (ADDR_W'(1) << size);
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    next_addr = burst == BURST_FIXED ? addr : burst == BURST_WRAP ? (addr & ~mask) | (inc & mask) : inc;
    strb = strb_of(addr, size);
    next_strb = strb_of(next_addr, size);
  end
endmodule

// File: rtl/axi_wr_burst_gen.sv
// axi_wr_burst_gen: AXI3 write-burst master driven by a single-descriptor command port
// cmd_*: descriptor in (valid/ready); done/done_resp/done_iderr: completion pulse out.
// AW*/W*/B*: AXI3 write address, data and response channels; all outputs are flops.
module axi_wr_burst_gen
  import axi_wr_burst_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                ACLK,
  input  logic                RESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                done,
  output logic [1:0]          done_resp,
  output logic                done_iderr,
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic [1:0]          AWLOCK,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ID_W-1:0]     WID,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);
  localparam int STRB_W = DATA_W / 8;
  state_t state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
  logic [3:0] len_q, len_d, beat_q, beat_d;
  logic [2:0] size_q, size_d;
  logic [1:0] burst_q, burst_d, resp_q, resp_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [STRB_W-1:0] strb_q, strb_d, cur_strb, next_strb;
  logic wlast_q, wlast_d, iderr_q, iderr_d;
  logic cmd_ready_q, cmd_ready_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic bready_q, bready_d, done_q, done_d;
  axi_beat_addr #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_beat (
    .addr(addr_q), .size(size_q), .burst(burst_q), .len(len_q),
    .next_addr(next_addr), .strb(cur_strb), .next_strb(next_strb)
  );
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    addr_d = addr_q;
    len_d = len_q;
    size_d = size_q;
    burst_d = burst_q;
    data_d = data_q;
    beat_d = beat_q;
    strb_d = strb_q;
    wlast_d = wlast_q;
    resp_d = resp_q;
    iderr_d = iderr_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        id_d = cmd_id;
        addr_d = cmd_addr;
        len_d = cmd_len;
        size_d = cmd_size;
        burst_d = cmd_burst;
        data_d = cmd_data;
        beat_d = '0;
        wlast_d = 1'b0;
        iderr_d = 1'b0;
        resp_d = cmd_illegal(cmd_size, cmd_burst, cmd_len) ? RESP_SLVERR : RESP_OKAY;
        state_d = cmd_illegal(cmd_size, cmd_burst, cmd_len) ? ST_DONE : ST_ADDR;
      end
      // strobe and WLAST are registered one beat ahead so W outputs come straight from flops
      ST_ADDR: if (AWREADY) begin
        state_d = ST_DATA;
        strb_d = cur_strb;
        wlast_d = len_q == 4'd0;
      end
      ST_DATA: if (WREADY) begin
        state_d = wlast_q ? ST_RESP : ST_DATA;
        beat_d = beat_q + 4'd1;
        addr_d = next_addr;
        data_d = data_q + DATA_W'(1);
        strb_d = next_strb;
        wlast_d = !wlast_q && beat_q + 4'd1 == len_q;
      end
      ST_RESP: if (BVALID) begin
        state_d = ST_DONE;
        resp_d = BRESP;
        iderr_d = BID != id_q;
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = state_d == ST_IDLE;
    awvalid_d = state_d == ST_ADDR;
    wvalid_d = state_d == ST_DATA;
    bready_d = state_d == ST_RESP;
    done_d = state_d == ST_DONE;
  end
  always_ff @(posedge ACLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      id_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      data_q <= '0;
      beat_q <= '0;
      strb_q <= '0;
      wlast_q <= 1'b0;
      resp_q <= '0;
      iderr_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      burst_q <= burst_d;
      data_q <= data_d;
      beat_q <= beat_d;
      strb_q <= strb_d;
      wlast_q <= wlast_d;
      resp_q <= resp_d;
      iderr_q <= iderr_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      done_q <= done_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign done = done_q;
  assign done_resp = resp_q;
  assign done_iderr = iderr_q;
  assign AWID = id_q;
  assign AWADDR = addr_q;
  assign AWLEN = len_q;
  assign AWSIZE = size_q;
  assign AWBURST = burst_q;
  assign AWLOCK = 2'b00;
  assign AWCACHE = 4'b0000;
  assign AWPROT = 3'b000;
  assign AWVALID = awvalid_q;
  assign WID = id_q;
  assign WDATA = data_q;
  assign WSTRB = strb_q;
  assign WLAST = wlast_q;
  assign WVALID = wvalid_q;
  assign BREADY = bready_q;
endmodule

// File: tb/tb_axi_wr_burst_gen.sv
// tb_axi_wr_burst_gen: directed self-checking bench for axi_wr_burst_gen
module tb_axi_wr_burst_gen;
  import axi_wr_burst_gen_pkg::*;
  logic ACLK = 1'b0, RESETn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [3:0] cmd_id = '0, cmd_len = '0;
  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic [2:0] cmd_size = '0;
  logic [1:0] cmd_burst = '0;
  logic done, done_iderr;
  logic [1:0] done_resp;
  logic [3:0] AWID, AWLEN, AWCACHE, WID, WSTRB;
  logic [31:0] AWADDR, WDATA;
  logic [2:0] AWSIZE, AWPROT;
  logic [1:0] AWBURST, AWLOCK;
  logic AWVALID, AWREADY = 1'b0, WLAST, WVALID, WREADY = 1'b0, BVALID = 1'b0, BREADY;
  logic [3:0] BID = '0;
  logic [1:0] BRESP = '0;
  always #5 ACLK = ~ACLK;
  axi_wr_burst_gen dut (
    .ACLK(ACLK), .RESETn(RESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .cmd_data(cmd_data), .done(done), .done_resp(done_resp),
    .done_iderr(done_iderr), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB),
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY), .BID(BID), .BRESP(BRESP),
    .BVALID(BVALID), .BREADY(BREADY)
  );
  int tests = 0, fails = 0;
  logic [31:0] b_addr[16], b_data[16];
  logic [3:0] b_strb[16];
  logic b_last[16];
  int n_beats, n_aw_hs, aw_cycles, aw_first, aw_hs_cyc, w_first, w_last_cyc, b_cyc;
  int first_done, n_done, stab_err, accept_wait;
  logic ready_after, got_iderr;
  logic [1:0] got_resp;

  // Slave model: issues one descriptor, answers AW/W/B, records beats and protocol violations.
  // BVALID is raised from the start so an early BREADY is caught.
  task automatic run(input wr_cmd_t c, input int aw_delay, input int stall_beat, input int stall_cycles,
                     input logic [3:0] bid, input logic [1:0] bresp);
    logic aw_hold, w_hold, b_clear, w_done;
    logic [44:0] aw_prev;
    logic [36:0] w_prev;
    int stall_left;
    n_beats = 0; n_aw_hs = 0; aw_cycles = 0; aw_first = -1; aw_hs_cyc = -1; w_first = -1;
    w_last_cyc = -1; b_cyc = -1; first_done = -1; n_done = 0; stab_err = 0; accept_wait = 0;
    ready_after = 1'b0; got_iderr = 1'bx; got_resp = 2'bxx;
    aw_hold = 1'b0; w_hold = 1'b0; b_clear = 1'b0; w_done = 1'b0; aw_prev = '0; w_prev = '0;
    stall_left = stall_cycles;
    while (!cmd_ready && accept_wait < 20) begin
      @(negedge ACLK);
      accept_wait++;
    end
    cmd_valid = 1'b1; cmd_id = c.id; cmd_addr = c.addr; cmd_len = c.len;
    cmd_size = c.size; cmd_burst = c.burst; cmd_data = c.data;
    BID = bid; BRESP = bresp; BVALID = 1'b1;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      if (b_clear) BVALID = 1'b0;
      if (BREADY && !w_done) stab_err++;
      if (BVALID && BREADY) begin
        b_clear = 1'b1;
        b_cyc = cyc;
      end
      if (aw_hold && (!AWVALID || {AWADDR, AWID, AWLEN, AWSIZE, AWBURST} !== aw_prev)) stab_err++;
      if (AWVALID) begin
        aw_cycles++;
        if (aw_first < 0) aw_first = cyc;
      end
      AWREADY = AWVALID && aw_cycles > aw_delay;
      if (AWVALID && AWREADY) begin
        n_aw_hs++;
        aw_hs_cyc = cyc;
      end
      aw_hold = AWVALID && !AWREADY;
      aw_prev = {AWADDR, AWID, AWLEN, AWSIZE, AWBURST};
      if (w_hold && (!WVALID || {WDATA, WSTRB, WLAST} !== w_prev)) stab_err++;
      WREADY = 1'b0;
      if (WVALID) begin
        if (w_first < 0) w_first = cyc;
        if (n_beats == stall_beat && stall_left > 0) stall_left--;
        else WREADY = 1'b1;
      end
      if (WVALID && WREADY && n_beats < 16) begin
        b_addr[n_beats] = dut.addr_q;
        b_data[n_beats] = WDATA;
        b_strb[n_beats] = WSTRB;
        b_last[n_beats] = WLAST;
        n_beats++;
        if (WLAST) begin
          w_done = 1'b1;
          w_last_cyc = cyc;
        end
      end
      w_hold = WVALID && !WREADY;
      w_prev = {WDATA, WSTRB, WLAST};
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = cyc;
          got_resp = done_resp;
          got_iderr = done_iderr;
        end
      end
      if (first_done >= 0 && cyc == first_done + 1) ready_after = cmd_ready;
      if (first_done >= 0 && cyc >= first_done + 2) break;
      @(negedge ACLK);
    end
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge ACLK);
    tests++;
    if ({cmd_ready, AWVALID, WVALID, WLAST, BREADY, done, done_iderr} !== 7'b0 || {AWADDR, WDATA, WSTRB, done_resp} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got ready=%b awv=%b wv=%b br=%b done=%b awaddr=%h wdata=%h want all 0",
               cmd_ready, AWVALID, WVALID, BREADY, done, AWADDR, WDATA);
    end
    RESETn = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_release_ready got %b want 0", cmd_ready); end
    @(negedge ACLK);
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset got %b want 1", cmd_ready); end
  endtask

  task automatic test_incr();
    wr_cmd_t c;
    logic [68:0] exp;
    c = '{id: 4'd1, addr: 32'h1000, len: 4'd3, size: 3'd2, burst: BURST_INCR, data: 32'h10};
    run(c, 0, 99, 0, 4'd1, RESP_OKAY);
    tests++;
    if (n_beats !== 4) begin fails++; $display("FAIL incr_beats got %0d want 4", n_beats); end
    for (int i = 0; i < 4; i++) begin
      exp = {32'h1000 + 32'(4 * i), 32'h10 + 32'(i), 4'hF, i == 3};
      tests++;
      if ({b_addr[i], b_data[i], b_strb[i], b_last[i]} !== exp) begin
        fails++;
        $display("FAIL incr_beat%0d got %h/%h/%h/%b want %h", i, b_addr[i], b_data[i], b_strb[i], b_last[i], exp);
      end
    end
    tests++;
    if (aw_first !== 1 || w_first !== aw_hs_cyc + 1 || w_last_cyc - w_first !== 3) begin
      fails++;
      $display("FAIL incr_latency got aw=%0d w=%0d aw_hs=%0d wlast=%0d want aw=1 w=aw_hs+1 span=3", aw_first, w_first, aw_hs_cyc, w_last_cyc);
    end
    tests++;
    if (n_done !== 1 || first_done !== b_cyc + 1 || ready_after !== 1'b1 || got_resp !== 2'b00 || got_iderr !== 1'b0) begin
      fails++;
      $display("FAIL incr_done got n=%0d at=%0d b=%0d rdy=%b resp=%b iderr=%b want n=1 at=b+1 rdy=1 resp=00 iderr=0",
               n_done, first_done, b_cyc, ready_after, got_resp, got_iderr);
    end
    tests++;
    if (stab_err !== 0) begin fails++; $display("FAIL incr_protocol got %0d violations want 0", stab_err); end
  endtask

  task automatic test_wrap();
    wr_cmd_t c;
    logic [31:0] ea[4], ed[4];
    ea = '{32'h1038, 32'h103C, 32'h1030, 32'h1034};
    ed = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2};
    c = '{id: 4'd2, addr: 32'h1038, len: 4'd3, size: 3'd2, burst: BURST_WRAP, data: 32'hFFFF_FFFF};
    run(c, 0, 99, 0, 4'd2, RESP_OKAY);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (b_addr[i] !== ea[i] || b_data[i] !== ed[i]) begin
        fails++;
        $display("FAIL wrap_beat%0d got addr=%h data=%h want addr=%h data=%h", i, b_addr[i], b_data[i], ea[i], ed[i]);
      end
    end
    tests++;
    if (n_beats !== 4 || n_done !== 1 || got_resp !== 2'b00) begin
      fails++;
      $display("FAIL wrap_done got beats=%0d done=%0d resp=%b want 4/1/00", n_beats, n_done, got_resp);
    end
  endtask

  task automatic test_incr_byte();
    wr_cmd_t c;
    logic [3:0] es[3];
    es = '{4'h2, 4'h4, 4'h8};
    c = '{id: 4'd3, addr: 32'h2001, len: 4'd2, size: 3'd0, burst: BURST_INCR, data: 32'hA};
    run(c, 0, 99, 0, 4'd3, RESP_OKAY);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (b_strb[i] !== es[i] || b_addr[i] !== 32'h2001 + 32'(i) || b_data[i] !== 32'hA + 32'(i) || b_last[i] !== (i == 2)) begin
        fails++;
        $display("FAIL byte_beat%0d got strb=%h addr=%h data=%h last=%b want strb=%h", i, b_strb[i], b_addr[i], b_data[i], b_last[i], es[i]);
      end
    end
    tests++;
    if (n_beats !== 3 || n_done !== 1) begin fails++; $display("FAIL byte_count got beats=%0d done=%0d want 3/1", n_beats, n_done); end
  endtask

  task automatic test_stall();
    wr_cmd_t c;
    c = '{id: 4'd4, addr: 32'h3000, len: 4'd3, size: 3'd2, burst: BURST_INCR, data: 32'h500};
    run(c, 5, 1, 3, 4'd4, RESP_OKAY);
    tests++;
    if (n_aw_hs !== 1 || aw_hs_cyc !== 6 || w_first !== 7) begin
      fails++;
      $display("FAIL stall_aw got hs=%0d at=%0d wfirst=%0d want 1 at 6 wfirst 7", n_aw_hs, aw_hs_cyc, w_first);
    end
    tests++;
    if (n_beats !== 4 || w_last_cyc - w_first !== 6) begin
      fails++;
      $display("FAIL stall_beats got %0d span=%0d want 4 span=6", n_beats, w_last_cyc - w_first);
    end
    tests++;
    if (stab_err !== 0) begin fails++; $display("FAIL stall_stable got %0d violations want 0", stab_err); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (b_data[i] !== 32'h500 + 32'(i) || b_addr[i] !== 32'h3000 + 32'(4 * i)) begin
        fails++;
        $display("FAIL stall_beat%0d got data=%h addr=%h want data=%h", i, b_data[i], b_addr[i], 32'h500 + 32'(i));
      end
    end
  endtask

  task automatic test_bresp();
    wr_cmd_t c;
    c = '{id: 4'd5, addr: 32'h5000, len: 4'd1, size: 3'd2, burst: BURST_INCR, data: 32'h0};
    run(c, 0, 99, 0, 4'd7, RESP_SLVERR);
    tests++;
    if (n_done !== 1 || got_resp !== 2'b10 || got_iderr !== 1'b1) begin
      fails++;
      $display("FAIL bresp_iderr got done=%0d resp=%b iderr=%b want 1/10/1", n_done, got_resp, got_iderr);
    end
    tests++;
    if (stab_err !== 0) begin fails++; $display("FAIL early_bready got %0d violations want 0", stab_err); end
  endtask

  task automatic test_illegal();
    wr_cmd_t c[3];
    c[0] = '{id: 4'd6, addr: 32'h6000, len: 4'd2, size: 3'd2, burst: BURST_WRAP, data: 32'h0};
    c[1] = '{id: 4'd6, addr: 32'h6000, len: 4'd1, size: 3'd3, burst: BURST_INCR, data: 32'h0};
    c[2] = '{id: 4'd6, addr: 32'h6000, len: 4'd1, size: 3'd2, burst: 2'b11, data: 32'h0};
    for (int i = 0; i < 3; i++) begin
      run(c[i], 0, 99, 0, 4'd6, RESP_OKAY);
      tests++;
      if (n_done !== 1 || first_done !== 1 || got_resp !== 2'b10 || aw_cycles !== 0 || n_beats !== 0 || ready_after !== 1'b1) begin
        fails++;
        $display("FAIL illegal%0d got done=%0d at=%0d resp=%b awv=%0d beats=%0d rdy=%b want 1 at 1 resp=10 no bus",
                 i, n_done, first_done, got_resp, aw_cycles, n_beats, ready_after);
      end
    end
  endtask

  task automatic test_reset_mid();
    wr_cmd_t c;
    int dn;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0;
    cmd_valid = 1'b1; cmd_id = 4'd8; cmd_addr = 32'h4000; cmd_len = 4'd7;
    cmd_size = 3'd2; cmd_burst = BURST_INCR; cmd_data = 32'h100;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    repeat (3) @(negedge ACLK);
    tests++;
    if (WVALID !== 1'b1 || WDATA !== 32'h102) begin fails++; $display("FAIL mid_beat2 got wv=%b data=%h want 1/102", WVALID, WDATA); end
    #2 RESETn = 1'b0;
    #1;
    tests++;
    if ({cmd_ready, AWVALID, WVALID, WLAST, BREADY, done} !== 6'b0 || WDATA !== 32'h0 || AWADDR !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset_outputs got rdy=%b awv=%b wv=%b br=%b done=%b wdata=%h want all 0", cmd_ready, AWVALID, WVALID, BREADY, done, WDATA);
    end
    AWREADY = 1'b0; WREADY = 1'b0;
    @(negedge ACLK);
    RESETn = 1'b1;
    dn = 0;
    repeat (10) begin
      @(negedge ACLK);
      if (done || AWVALID || WVALID) dn++;
    end
    tests++;
    if (dn !== 0) begin fails++; $display("FAIL mid_no_done got %0d active cycles want 0", dn); end
    c = '{id: 4'd9, addr: 32'h7000, len: 4'd1, size: 3'd2, burst: BURST_INCR, data: 32'h77};
    run(c, 0, 99, 0, 4'd9, RESP_OKAY);
    tests++;
    if (accept_wait !== 0 || n_done !== 1 || n_beats !== 2 || b_data[1] !== 32'h78 || got_resp !== 2'b00) begin
      fails++;
      $display("FAIL post_reset_txn got wait=%0d done=%0d beats=%0d d1=%h resp=%b want 0/1/2/78/00", accept_wait, n_done, n_beats, b_data[1], got_resp);
    end
  endtask

  task automatic test_back_to_back();
    wr_cmd_t c;
    c = '{id: 4'd10, addr: 32'h8000, len: 4'd0, size: 3'd1, burst: BURST_FIXED, data: 32'h1};
    run(c, 0, 99, 0, 4'd10, RESP_OKAY);
    c = '{id: 4'd11, addr: 32'h8002, len: 4'd2, size: 3'd1, burst: BURST_FIXED, data: 32'h2};
    run(c, 0, 99, 0, 4'd11, RESP_OKAY);
    tests++;
    if (accept_wait !== 0 || n_done !== 1 || n_beats !== 3) begin
      fails++;
      $display("FAIL b2b_second got wait=%0d done=%0d beats=%0d want 0/1/3", accept_wait, n_done, n_beats);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (b_addr[i] !== 32'h8002 || b_strb[i] !== 4'hC || b_data[i] !== 32'h2 + 32'(i)) begin
        fails++;
        $display("FAIL fixed_beat%0d got addr=%h strb=%h data=%h want 8002/C/%h", i, b_addr[i], b_strb[i], b_data[i], 32'h2 + 32'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_incr_byte();
    test_stall();
    test_bresp();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
